// File: rtl/ysyx_041514_pipe_ctrl.sv
// ysyx_041514_pipe_ctrl: pipeline stall/flush/redirect controller.
// Defining YSYX_041514_STALL_WATCHDOG_EN adds a sticky stall watchdog (WDT_LIMIT cycles).
module ysyx_041514_pipe_ctrl #(
  parameter int unsigned WDT_LIMIT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req_i,
  input  logic        id_stall_req_i,
  input  logic        ex_stall_req_i,
  input  logic        mem_stall_req_i,
  input  logic        ex_redirect_valid_i,
  input  logic [63:0] ex_redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [63:0] trap_pc_i,
  input  logic        icache_busy_i,
  output logic [5:0]  stall_valid_o,
  output logic [5:0]  flush_valid_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o,
  output logic        wdt_timeout_o
);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;
  state_t state, state_nxt;
  logic [63:0] pc_q;
  logic [3:0] req;
  logic [5:0] base_stall, bubble, ev_flush, stall, flush;
  logic run, ex_ev, ev, redirect;
  assign run = state == RUN;
  assign ex_ev = ex_redirect_valid_i && run;
  assign ev = trap_valid_i || ex_ev;
  // IF requests only matter in RUN; while redirecting, the PC/IF pair is owned by the FSM
  assign req = {mem_stall_req_i, ex_stall_req_i, id_stall_req_i, if_stall_req_i && run};
  always_comb begin
    base_stall = req[3] ? 6'b011111 : req[2] ? 6'b001111 : req[1] ? 6'b000111 : req[0] ? 6'b000011 : 6'b0;
    bubble = req[3] ? 6'b100000 : req[2] ? 6'b010000 : req[1] ? 6'b001000 : req[0] ? 6'b000100 : 6'b0;
    ev_flush = trap_valid_i ? 6'b011110 : ex_ev ? 6'b001110 : 6'b0;
    stall = run ? base_stall : base_stall & 6'b111100;
    flush = bubble | ev_flush;
    redirect = 1'b0;
    state_nxt = state;
    case (state)
      RUN: if (ev) begin
        stall[0] = 1'b1;
        state_nxt = icache_busy_i ? DRAIN : FLUSH;
      end
      DRAIN: begin
        stall[0] = 1'b1;
        flush[1] = 1'b1;
        state_nxt = (icache_busy_i || trap_valid_i) ? DRAIN : FLUSH;
      end
      FLUSH: begin
        flush[1] = 1'b1;
        stall[0] = trap_valid_i;
        redirect = !trap_valid_i;
        state_nxt = trap_valid_i ? (icache_busy_i ? DRAIN : FLUSH) : RUN;
      end
      default: state_nxt = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc_q <= 64'h0;
    end else begin
      state <= state_nxt;
      if (ev) pc_q <= trap_valid_i ? trap_pc_i : ex_redirect_pc_i;
    end
  end
  assign stall_valid_o = rst ? 6'b0 : stall;
  assign flush_valid_o = rst ? 6'b0 : flush;
  assign redirect_valid_o = !rst && redirect;
  assign redirect_pc_o = rst ? 64'h0 : pc_q;
`ifdef YSYX_041514_STALL_WATCHDOG_EN
  logic [31:0] wdt_cnt;
  logic wdt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt <= 32'h0;
      wdt_q <= 1'b0;
    end else begin
      wdt_cnt <= stall[0] ? wdt_cnt + 32'd1 : 32'h0;
      if (stall[0] && wdt_cnt + 32'd1 >= WDT_LIMIT) wdt_q <= 1'b1;
    end
  end
  assign wdt_timeout_o = wdt_q && !rst;
`else
  logic [31:0] unused_wdt_limit;
  assign unused_wdt_limit = WDT_LIMIT;
  assign wdt_timeout_o = 1'b0;
`endif
endmodule

// File: doc/ysyx_041514_pipe_ctrl.md
YSYX_041514_PIPE_CTRL -- requirements
Module: ysyx_041514_pipe_ctrl

Interface
REQ-001 Parameter: WDT_LIMIT, default 65535, number of consecutive PC-stall cycles before watchdog timeout (used only when the watchdog is compiled in).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: if_stall_req_i  input  1  icache miss; IF cannot accept a new fetch.
REQ-005 Port: id_stall_req_i  input  1  load-use hazard in ID.
REQ-006 Port: ex_stall_req_i  input  1  multi-cycle EX operation busy.
REQ-007 Port: mem_stall_req_i  input  1  dcache busy.
REQ-008 Port: ex_redirect_valid_i  input  1  branch mispredict from EX.
REQ-009 Port: ex_redirect_pc_i  input  64  correct target from EX.
REQ-010 Port: trap_valid_i  input  1  trap/interrupt/fence.i from MEM.
REQ-011 Port: trap_pc_i  input  64  trap target from MEM.
REQ-012 Port: icache_busy_i  input  1  fetch outstanding in icache.
REQ-013 Port: stall_valid_o  output  6  per-stage stall; bit 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-014 Port: flush_valid_o  output  6  per-stage flush, same bit order.
REQ-015 Port: redirect_valid_o  output  1  PC register loads redirect_pc_o this cycle.
REQ-016 Port: redirect_pc_o  output  64  registered redirect target.
REQ-017 Port: wdt_timeout_o  output  1  sticky stall-watchdog flag.

Function
REQ-018 Stall rule, state RUN: a request at stage k (IF=1, ID=2, EX=3, MEM=4) asserts stall bits 0..k; the highest requesting stage wins; WB (bit 5) is never stalled.
REQ-019 Bubble rule: when stage k is the highest stalled stage, flush bit k+1 is asserted; flush bit 0 is always 0.
REQ-020 FSM states: RUN, DRAIN, FLUSH; encoding is free.
REQ-021 Source priority: trap_valid_i beats ex_redirect_valid_i in the same cycle.
REQ-022 RUN plus event: capture the target into a 64-bit register; assert stall bit 0; assert flush bits 1-3 (EX redirect) or bits 1-4 (trap); go to DRAIN if icache_busy_i=1, else FLUSH.
REQ-023 DRAIN: stall bit 0 = 1; flush bit 1 = 1 (discard returning fetch); go to FLUSH when icache_busy_i=0.
REQ-024 FLUSH: redirect_valid_o=1; stall bit 0 forced 0 regardless of stall requests; flush bit 1 = 1; go to RUN.
REQ-025 Event-to-redirect latency: 1 cycle minimum (event in cycle N, redirect_valid_o in N+1), plus the number of icache_busy_i cycles.
REQ-026 In DRAIN/FLUSH, ex_redirect_valid_i is ignored (wrong-path instruction).
REQ-027 trap_valid_i in DRAIN: overwrite the target, flush bits 1-4, stay in DRAIN.
REQ-028 trap_valid_i in FLUSH: suppress redirect_valid_o, overwrite the target, flush bits 1-4, go to DRAIN or FLUSH per icache_busy_i.
REQ-029 In DRAIN/FLUSH, stall requests for stages 2-4 still apply per REQ-018 to bits 2..k.
REQ-030 redirect_pc_o holds its last captured value when redirect_valid_o=0.

Reset
REQ-031 While rst=1 and on the cycle after: state=RUN; stall_valid_o=6'b0; flush_valid_o=6'b0; redirect_valid_o=0; redirect_pc_o=64'h0; wdt_timeout_o=0; watchdog counter=0.
REQ-032 rst asserted mid-DRAIN/FLUSH abandons the pending redirect; no redirect_valid_o follows.

Configuration
REQ-033 Macro YSYX_041514_STALL_WATCHDOG_EN defined: a 32-bit counter increments each cycle stall bit 0 = 1 and clears when it is 0.
REQ-034 With the watchdog enabled, the counter reaching WDT_LIMIT sets wdt_timeout_o, which stays set until rst.
REQ-035 Macro undefined: no counter is built; wdt_timeout_o is tied to 0.

Verification
REQ-036 mem_stall_req_i=1 and id_stall_req_i=1 in RUN -> stall_valid_o=6'b011111, flush_valid_o=6'b100000.
REQ-037 ex_redirect_valid_i=1 with pc 0x80000100, icache_busy_i=0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x80000100; cycle after, state RUN.
REQ-038 Same redirect with icache_busy_i=1 for 3 cycles -> stall bit 0 held 4 cycles; redirect_valid_o one cycle after busy drops.
REQ-039 ex_redirect (0x80000100) and trap (0x80000004) in the same cycle -> redirect_pc_o=0x80000004, flush_valid_o=6'b011110 in the capture cycle.
REQ-040 With YSYX_041514_STALL_WATCHDOG_EN and WDT_LIMIT=8, if_stall_req_i held 8 cycles -> wdt_timeout_o=1; it remains 1 after the stall is released until rst.
